qpsk_rx_frame_ctrl: RTL

Receive-side frame controller for the QPSK link. It accepts symbol-rate I/Q samples and decodes each sample to a dibit. It hunts for a sync word, then packs the payload dibits into bytes and hands them downstream over a valid/ready interface. It sits between the symbol slicer and the byte sink (UART/packet buffer), and tracks frame boundaries, symbol errors and overflow.

---
 rtl/qpsk_pkg.sv | 20 ++
 rtl/qpsk_byte_outreg.sv | 38 +++
 rtl/qpsk_rx_frame_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/qpsk_pkg.sv
// qpsk_pkg: shared types, I/Q level constants and symbol decoder for the QPSK receive path.
// Contents: state_t (FSM encoding exposed on state_o), POS/ZERO/NEG levels, dibit_decode().
package qpsk_pkg;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HUNT    = 2'd1,
    S_PAYLOAD = 2'd2,
    S_DONE    = 2'd3
  } state_t;
  localparam logic [1:0] POS  = 2'b01;
  localparam logic [1:0] ZERO = 2'b00;
  localparam logic [1:0] NEG  = 2'b11;
  // Returns {valid, dibit}; any code off the four constellation points is invalid.
  function automatic logic [2:0] dibit_decode(input logic [1:0] i_lvl, input logic [1:0] q_lvl);
    return ({i_lvl, q_lvl} == {POS, ZERO}) ? 3'b100 :
           ({i_lvl, q_lvl} == {ZERO, POS}) ? 3'b101 :
           ({i_lvl, q_lvl} == {NEG, ZERO}) ? 3'b111 :
           ({i_lvl, q_lvl} == {ZERO, NEG}) ? 3'b110 : 3'b000;
  endfunction
endpackage

// File: rtl/qpsk_byte_outreg.sv
// qpsk_byte_outreg: single-entry valid/ready byte register with drop-on-full and sticky overflow.
// Ports: CLOCK_256/reset (async, active-high); i_load offers i_data; i_ready is the sink ready;
//        o_data/o_valid present the held byte; o_overflow is set when an offered byte is dropped.
module qpsk_byte_outreg (
  input  logic       CLOCK_256,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_overflow
);
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_overflow;
  logic       w_take;
  // A byte can land when the register is empty or is being drained this very cycle.
  assign w_take = ~r_valid | i_ready;
  always_ff @(posedge CLOCK_256 or posedge reset) begin
    if (reset) begin
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (i_load && w_take) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
      if (i_load && !w_take) r_overflow <= 1'b1;
    end
  end
  assign o_data     = r_data;
  assign o_valid    = r_valid;
  assign o_overflow = r_overflow;
endmodule

// File: rtl/qpsk_rx_frame_ctrl.sv
// qpsk_rx_frame_ctrl: hunts for a sync word in decoded QPSK dibits, then packs payload dibits into bytes.
// Ports: CLOCK_256/reset (async, active-high); enable runs the hunt/receive FSM; sym_valid/I/Q carry
//        symbols; byte_data/byte_valid/byte_ready form the byte output handshake; frame_active,
//        frame_done, overflow, sym_err_count and state_o report frame progress and errors.
module qpsk_rx_frame_ctrl
  import qpsk_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD   = 8'hD3,
  parameter int         FRAME_BYTES = 16,
  parameter int         ERR_W       = 8
) (
  input  logic             CLOCK_256,
  input  logic             reset,
  input  logic             enable,
  input  logic             sym_valid,
  input  logic [1:0]       I,
  input  logic [1:0]       Q,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             frame_active,
  output logic             frame_done,
  output logic             overflow,
  output logic [ERR_W-1:0] sym_err_count,
  output logic [1:0]       state_o
);
  localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);
  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_sync;
  logic [2:0]       r_fill;
  logic [1:0]       r_dib;
  logic [7:0]       r_bytes;
  logic [7:0]       r_asm;
  logic [ERR_W-1:0] r_err;
  logic             r_active;
  logic             r_done;
  logic [2:0]       w_dec;
  logic             w_sym_ok;
  logic [7:0]       w_shift;
  logic [2:0]       w_fill_nx;
  logic             w_sync_hit;
  logic             w_pay_sym;
  logic             w_byte_done;
  logic             w_last;
  logic             w_err_inc;
  logic [7:0]       w_asm_byte;
  assign w_dec       = dibit_decode(I, Q);
  assign w_sym_ok    = w_dec[2];
  assign w_shift     = {r_sync[5:0], w_dec[1:0]};
  assign w_fill_nx   = r_fill + 3'd1;
  // Sync only counts once four valid dibits have filled the window since the last clear.
  assign w_sync_hit  = (r_state == S_HUNT) && sym_valid && w_sym_ok &&
                       (w_shift == SYNC_WORD) && (w_fill_nx >= 3'd4);
  assign w_pay_sym   = (r_state == S_PAYLOAD) && sym_valid;
  assign w_byte_done = w_pay_sym && (r_dib == 2'd3);
  assign w_last      = w_byte_done && (r_bytes == LAST_BYTE);
  assign w_err_inc   = sym_valid && !w_sym_ok && (r_state == S_HUNT || r_state == S_PAYLOAD);
  // Invalid payload symbols still occupy a dibit slot, filled with 00.
  assign w_asm_byte  = {r_asm[5:0], w_sym_ok ? w_dec[1:0] : 2'b00};
  always_ff @(posedge CLOCK_256 or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_next = S_HUNT;
        S_HUNT:    w_next = w_sync_hit ? S_PAYLOAD : S_HUNT;
        S_PAYLOAD: w_next = w_last ? S_DONE : S_PAYLOAD;
        S_DONE:    w_next = S_HUNT;
        default:   w_next = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge CLOCK_256 or posedge reset) begin
    if (reset) begin
      r_sync   <= '0;
      r_fill   <= '0;
      r_dib    <= '0;
      r_bytes  <= '0;
      r_asm    <= '0;
      r_err    <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // Decoding the next state keeps the status flags cycle-aligned with r_state.
      r_active <= (w_next == S_PAYLOAD);
      r_done   <= (w_next == S_DONE);
      // The sync window is held clear outside HUNT, so every entry to HUNT starts empty.
      if (r_state != S_HUNT) begin
        r_sync <= '0;
        r_fill <= '0;
      end else if (sym_valid) begin
        r_sync <= w_sym_ok ? w_shift : 8'd0;
        r_fill <= !w_sym_ok ? 3'd0 : (r_fill == 3'd4) ? 3'd4 : w_fill_nx;
      end
      if (w_sync_hit) begin
        r_dib   <= '0;
        r_bytes <= '0;
        r_asm   <= '0;
      end else if (w_pay_sym) begin
        r_dib <= r_dib + 2'd1;
        r_asm <= w_asm_byte;
        if (w_byte_done) r_bytes <= r_bytes + 8'd1;
      end
      if (w_err_inc && r_err != {ERR_W{1'b1}}) r_err <= r_err + 1'b1;
    end
  end
  qpsk_byte_outreg u_outreg (
    .CLOCK_256  (CLOCK_256),
    .reset      (reset),
    .i_load     (w_byte_done),
    .i_data     (w_asm_byte),
    .i_ready    (byte_ready),
    .o_data     (byte_data),
    .o_valid    (byte_valid),
    .o_overflow (overflow)
  );
  assign frame_active  = r_active;
  assign frame_done    = r_done;
  assign sym_err_count = r_err;
  assign state_o       = r_state;
endmodule
